ram_dump_reader: RTL and testbench
==================================

// Module: ram_dump_reader
// PURPOSE
//  Bus-mastered SRAM read-out engine, the read-side counterpart to preloading sram0 from a hex image.
//  On a start pulse it reads N 32-bit words from base_addr over AHB-Lite.
//  It emits them as a byte stream, little-endian per word: byte lane 0 first, then 1, 2, 3.
//  Sits on a spare AHB-Lite master port of fpgaboy_core; feeds a debug UART TX or a sim-only dump sink.
// PARAMETERS
//  W_ADDR  32  AHB address width; address arithmetic is modulo 2^W_ADDR
//  W_CNT   16  width of word_count; max transfer 2^W_CNT-1 words
// PORTS
//  clk          in   1        system clock; all logic rising-edge
//  rst          in   1        synchronous, active-high reset
//  start        in   1        1-cycle request; sampled only in IDLE
//  base_addr    in   W_ADDR   first word address; bits [1:0] ignored (forced 0)
//  word_count   in   W_CNT    number of words to read
//  busy         out  1        high from cycle after accepted start until done
//  done         out  1        1-cycle pulse at end of job (normal, zero-length or error)
//  err          out  1        sticky bus-error flag; cleared by next accepted start
//  ahbl_htrans  out  2        IDLE(00) or NONSEQ(10) only
//  ahbl_haddr   out  W_ADDR   word-aligned address
//  ahbl_hwrite  out  1        tied 0
//  ahbl_hsize   out  3        tied 3'b010 (word)
//  ahbl_hburst  out  3        tied 3'b000 (SINGLE)
//  ahbl_hprot   out  4        tied 4'b0011
//  ahbl_hmastlock out 1       tied 0
//  ahbl_hwdata  out  32       tied 0
//  ahbl_hready  in   1        AHB-Lite transfer ready
//  ahbl_hresp   in   1        AHB-Lite error response
//  ahbl_hrdata  in   32       read data
//  out_data     out  8        stream byte
//  out_valid    out  1        stream valid
//  out_ready    in   1        stream ready; a transfer occurs when out_valid & out_ready
// BEHAVIOUR
//  Reset values: busy=0, done=0, err=0, htrans=IDLE, haddr=0, out_valid=0, out_data=0; state=IDLE.
//  rst wins over every other input in the same cycle; a job in flight is abandoned with no done pulse.
//  An AHB data phase still pending when rst asserts is not tracked; the interconnect resets with the system.
//  States:
//   IDLE:  start & word_count!=0 -> ADDR. Latch addr=base_addr&~3, remaining=word_count, clear err.
//          start & word_count==0 -> pulse done next cycle; busy stays 0.
//   ADDR:  htrans=NONSEQ, haddr=addr. Both hold stable until sampled with hready=1, then -> DATA.
//   DATA:  htrans=IDLE. Wait for hready=1.
//          On hresp=1 (either cycle of the 2-cycle error response): set err; suppress capture and stream.
//          On the hready=1 cycle with err set: -> IDLE, pulse done.
//          On hready=1 with hresp=0: capture hrdata into buf, byte_idx=0 -> SHIFT.
//   SHIFT: out_valid=1, out_data=buf[8*byte_idx+:8]. Each handshake advances byte_idx.
//          Handshake at byte_idx=3: remaining-=1.
//           If the new remaining==0 -> IDLE and pulse done.
//           Else addr+=4 (wraps at 2^W_ADDR) -> ADDR.
//  Stream rules:
//   - out_valid never drops and out_data never changes while out_ready=0 (AXI-stream style).
//   - out_valid is 0 outside SHIFT.
//  Single outstanding AHB transfer; no pipelining, no bursts.
//  Throughput: 2 bus cycles + 4 stream cycles per word at zero wait states.
//  Latency: start -> first NONSEQ = 1 cycle; last byte handshake -> done = 1 cycle.
//  busy is high exactly while state != IDLE. start while busy is ignored, with no error.
//  done and a new start can coincide only if the new start arrives in the cycle after done (IDLE).
// STRUCTURE
//  ahbl_defs.vh (shared include): HTRANS_IDLE/NONSEQ, HSIZE_WORD, HBURST_SINGLE localparams.
//  ahbl_defs.vh is reused by other AHB-Lite masters in fpgaboy_core.
//  One natural sub-module: ram_dump_byte_serialiser.
//   Function: 32-bit load port plus 2-bit byte counter to 8-bit valid/ready stream, with a last-byte strobe.
//  The FSM, address and remaining-count registers stay in the top level.
// TESTING
//  1. RAM 0x2000_0000 = 0x44332211, 0x88776655; start(base=0x2000_0000,count=2), out_ready=1
//     -> bytes 11 22 33 44 55 66 77 88, one done pulse, err=0.
//  2. Same as 1 with out_ready toggling randomly
//     -> identical byte sequence; out_data stable whenever out_valid & !out_ready.
//  3. Slave inserts 3 wait states per transfer
//     -> NONSEQ/haddr held until hready; data correct; total words = 2.
//  4. Error slave at 0x4000_0000; start(base=0x4000_0000,count=4)
//     -> err=1, done pulse, zero bytes emitted, htrans IDLE after the first transfer.
//  5. start(count=0) -> done pulse next cycle, busy never high, no AHB traffic.
//     start(base=0x2000_0003) -> first haddr=0x2000_0000.
//  6. rst asserted mid-SHIFT on byte 2 -> next cycle busy=0, out_valid=0, no done.
//     A subsequent start(count=1) completes normally.

Source files
------------

// File: rtl/ram_dump_reader_pkg.sv
// Shared types and AHB-Lite encodings for the SRAM dump reader.
// Only the transfer kinds this single-word read master ever issues are defined here.
package ram_dump_reader_pkg;

    localparam logic [1:0] HTRANS_IDLE    = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ  = 2'b10;
    localparam logic [2:0] HSIZE_WORD     = 3'b010;
    localparam logic [2:0] HBURST_SINGLE  = 3'b000;
    localparam logic [3:0] HPROT_DATA_PRV = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_DATA  = 2'd2,
        ST_SHIFT = 2'd3
    } state_t;

    // Little-endian lane select: lane 0 is bits [7:0].
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/ram_dump_reader_if.sv
// Control, AHB-Lite master and byte-stream signals of the dump reader.
// master = reader side, slave = system/bench side.
interface ram_dump_reader_if #(
    parameter int W_ADDR = 32,
    parameter int W_CNT  = 16
) ();

    logic              start;
    logic [W_ADDR-1:0] base_addr;
    logic [W_CNT-1:0]  word_count;
    logic              busy;
    logic              done;
    logic              err;

    logic [1:0]        ahbl_htrans;
    logic [W_ADDR-1:0] ahbl_haddr;
    logic              ahbl_hwrite;
    logic [2:0]        ahbl_hsize;
    logic [2:0]        ahbl_hburst;
    logic [3:0]        ahbl_hprot;
    logic              ahbl_hmastlock;
    logic [31:0]       ahbl_hwdata;
    logic              ahbl_hready;
    logic              ahbl_hresp;
    logic [31:0]       ahbl_hrdata;

    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        input  start, base_addr, word_count,
        output busy, done, err,
        output ahbl_htrans, ahbl_haddr, ahbl_hwrite, ahbl_hsize, ahbl_hburst,
        output ahbl_hprot, ahbl_hmastlock, ahbl_hwdata,
        input  ahbl_hready, ahbl_hresp, ahbl_hrdata,
        output out_data, out_valid,
        input  out_ready
    );

    modport slave (
        output start, base_addr, word_count,
        input  busy, done, err,
        input  ahbl_htrans, ahbl_haddr, ahbl_hwrite, ahbl_hsize, ahbl_hburst,
        input  ahbl_hprot, ahbl_hmastlock, ahbl_hwdata,
        output ahbl_hready, ahbl_hresp, ahbl_hrdata,
        input  out_data, out_valid,
        output out_ready
    );

endinterface

// File: rtl/ram_dump_byte_serialiser.sv
// Turns a loaded 32-bit word into four little-endian bytes on a valid/ready stream.
// First byte valid the cycle after load; holds byte while out_rdy_i=0; last_o marks the lane-3 handshake.
module ram_dump_byte_serialiser
    import ram_dump_reader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] load_dat_i,
    output logic [7:0]  out_dat_o,
    output logic        out_vld_o,
    input  logic        out_rdy_i,
    output logic        last_o
);

    logic [31:0] buf_q, buf_d;
    logic [1:0]  idx_q, idx_d;
    logic        vld_q, vld_d;
    logic        hs;

    assign hs        = vld_q & out_rdy_i;
    assign last_o    = hs & (idx_q == 2'd3);
    assign out_vld_o = vld_q;
    assign out_dat_o = vld_q ? byte_lane(buf_q, idx_q) : 8'h00;

    always_comb begin
        buf_d = buf_q;
        idx_d = idx_q;
        vld_d = vld_q;
        if (load_i) begin
            buf_d = load_dat_i;
            idx_d = 2'd0;
            vld_d = 1'b1;
        end else if (hs) begin
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q <= 32'h0;
            idx_q <= 2'd0;
            vld_q <= 1'b0;
        end else begin
            buf_q <= buf_d;
            idx_q <= idx_d;
            vld_q <= vld_d;
        end
    end

endmodule

// File: rtl/ram_dump_reader.sv
// Reads word_count words from base_addr over AHB-Lite, one outstanding transfer, and streams them as bytes.
// First NONSEQ one cycle after start; stream stalls hold the engine in SHIFT, bus stalls hold it in ADDR/DATA.
module ram_dump_reader
    import ram_dump_reader_pkg::*;
#(
    parameter int W_ADDR = 32,
    parameter int W_CNT  = 16
) (
    input  logic              clk,
    input  logic              rst,
    ram_dump_reader_if.master bus
);

    state_t            state_q, state_d;
    logic [W_ADDR-1:0] addr_q, addr_d;
    logic [W_CNT-1:0]  rem_q, rem_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              ser_load;
    logic              ser_last;

    assign bus.busy           = (state_q != ST_IDLE);
    assign bus.done           = done_q;
    assign bus.err            = err_q;
    assign bus.ahbl_htrans    = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.ahbl_haddr     = addr_q;
    assign bus.ahbl_hwrite    = 1'b0;
    assign bus.ahbl_hsize     = HSIZE_WORD;
    assign bus.ahbl_hburst    = HBURST_SINGLE;
    assign bus.ahbl_hprot     = HPROT_DATA_PRV;
    assign bus.ahbl_hmastlock = 1'b0;
    assign bus.ahbl_hwdata    = 32'h0;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        err_d    = err_q;
        done_d   = 1'b0;
        ser_load = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.word_count != '0) begin
                        state_d = ST_ADDR;
                        addr_d  = bus.base_addr & ~W_ADDR'(3);
                        rem_d   = bus.word_count;
                        err_d   = 1'b0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (bus.ahbl_hready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                // An error response spans two cycles; the flag is set on the first and the job ends on the second.
                if (bus.ahbl_hresp) begin
                    err_d = 1'b1;
                end
                if (bus.ahbl_hready) begin
                    if (bus.ahbl_hresp || err_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        ser_load = 1'b1;
                        state_d  = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (ser_last) begin
                    rem_d = rem_q - W_CNT'(1);
                    if (rem_q == W_CNT'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        addr_d  = addr_q + W_ADDR'(4);
                        state_d = ST_ADDR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    ram_dump_byte_serialiser u_ser (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ser_load),
        .load_dat_i (bus.ahbl_hrdata),
        .out_dat_o  (bus.out_data),
        .out_vld_o  (bus.out_valid),
        .out_rdy_i  (bus.out_ready),
        .last_o     (ser_last)
    );

endmodule

// File: tb/tb_ram_dump_reader.sv
// Bench for ram_dump_reader: AHB-Lite slave model, byte scoreboard, directed jobs.
module tb_ram_dump_reader;
    import ram_dump_reader_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;

    ram_dump_reader_if bus ();

    ram_dump_reader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    logic [7:0] exp_q[$];
    // stimulus-owned
    int rdy_mode = 0;
    int wait_cfg = 0;
    int job_id   = 0;
    int done_before, bytes_before, xfer_before, busy_before, start_cyc;
    // monitor-owned
    int bytes_out = 0;
    int done_cnt  = 0;
    int done_cyc  = 0;
    int busy_cnt  = 0;
    // slave-owned
    int          n_xfer       = 0;
    int          seen_job     = 0;
    int          first_ns_cyc = 0;
    logic [31:0] first_addr   = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h2000_0000: return 32'h4433_2211;
            32'h2000_0004: return 32'h8877_6655;
            32'h3000_0000: return 32'hDDCC_BBAA;
            default:       return 32'hDEAD_BEEF;
        endcase
    endfunction

    // AHB-Lite slave: decides hready/hresp for the current cycle at the falling edge.
    initial begin
        bit          dp_active = 0;
        bit          dp_err = 0;
        bit          dp_err_stage = 0;
        int          dp_wait = 0;
        logic [31:0] dp_addr = 32'h0;
        bit          prev_ns_wait = 0;
        logic [31:0] prev_addr = 32'h0;
        bus.ahbl_hready = 1'b1;
        bus.ahbl_hresp  = 1'b0;
        bus.ahbl_hrdata = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                dp_active       = 0;
                prev_ns_wait    = 0;
                bus.ahbl_hready = 1'b1;
                bus.ahbl_hresp  = 1'b0;
            end else begin
                if (prev_ns_wait) begin
                    check("nonseq_held", {30'h0, bus.ahbl_htrans}, {30'h0, HTRANS_NONSEQ});
                    check("haddr_held", bus.ahbl_haddr, prev_addr);
                end
                if (dp_active && dp_wait > 0) begin
                    bus.ahbl_hready = 1'b0;
                    bus.ahbl_hresp  = 1'b0;
                    dp_wait--;
                end else if (dp_active && dp_err) begin
                    bus.ahbl_hready = dp_err_stage;
                    bus.ahbl_hresp  = 1'b1;
                    dp_err_stage    = 1;
                end else if (dp_active) begin
                    bus.ahbl_hready = 1'b1;
                    bus.ahbl_hresp  = 1'b0;
                    bus.ahbl_hrdata = mem_rd(dp_addr);
                end else begin
                    bus.ahbl_hready = 1'b1;
                    bus.ahbl_hresp  = 1'b0;
                end
                if (bus.ahbl_hready) dp_active = 0;
                if (bus.ahbl_htrans == HTRANS_NONSEQ && bus.ahbl_hready) begin
                    dp_active    = 1;
                    dp_addr      = bus.ahbl_haddr;
                    dp_wait      = wait_cfg;
                    dp_err       = (bus.ahbl_haddr[31:28] == 4'h4);
                    dp_err_stage = 0;
                    n_xfer++;
                    if (seen_job != job_id) begin
                        seen_job     = job_id;
                        first_ns_cyc = cyc;
                        first_addr   = bus.ahbl_haddr;
                    end
                end
                prev_ns_wait = (bus.ahbl_htrans == HTRANS_NONSEQ) && !bus.ahbl_hready;
                prev_addr    = bus.ahbl_haddr;
            end
        end
    end

    // Stream monitor and scoreboard.
    initial begin
        bit         prev_stall = 0;
        logic [7:0] prev_dat = 8'h0;
        logic [7:0] exp_b;
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            bus.out_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (rst) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid_held", {31'h0, bus.out_valid}, 32'h1);
                    check("stall_data_held", {24'h0, bus.out_data}, {24'h0, prev_dat});
                end
                if (bus.out_valid && bus.out_ready) begin
                    bytes_out++;
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL stream_byte: got unexpected 0x%02h, expected no byte", bus.out_data);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("stream_byte", {24'h0, bus.out_data}, {24'h0, exp_b});
                    end
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_dat   = bus.out_data;
                if (bus.done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    check("busy_low_at_done", {31'h0, bus.busy}, 32'h0);
                end
                if (bus.busy) busy_cnt++;
            end
        end
    end

    task automatic push4(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
        exp_q.push_back(b3);
    endtask

    // Called at falling edge + 2.
    task automatic start_job(input logic [31:0] base, input logic [15:0] cnt);
        job_id++;
        done_before    = done_cnt;
        bytes_before   = bytes_out;
        xfer_before    = n_xfer;
        busy_before    = busy_cnt;
        start_cyc      = cyc;
        bus.start      = 1'b1;
        bus.base_addr  = base;
        bus.word_count = cnt;
        @(negedge clk); #2;
        bus.start      = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (done_cnt == done_before && t < 3000) begin
            @(negedge clk); #2;
            t++;
        end
        check({name, "_done_seen"}, 32'(done_cnt != done_before), 32'h1);
        repeat (6) @(negedge clk);
        #2;
        check({name, "_done_pulses"}, 32'(done_cnt - done_before), 32'h1);
        check({name, "_bytes_left"}, 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        int t;
        bus.start      = 1'b0;
        bus.base_addr  = 32'h0;
        bus.word_count = 16'h0;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk); #2;
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_done", {31'h0, bus.done}, 32'h0);
        check("rst_err", {31'h0, bus.err}, 32'h0);
        check("rst_htrans", {30'h0, bus.ahbl_htrans}, 32'h0);
        check("rst_haddr", bus.ahbl_haddr, 32'h0);
        check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("rst_out_data", {24'h0, bus.out_data}, 32'h0);

        // 1: two words, always ready
        push4(8'h11, 8'h22, 8'h33, 8'h44);
        push4(8'h55, 8'h66, 8'h77, 8'h88);
        start_job(32'h2000_0000, 16'd2);
        wait_done("t1");
        check("t1_err", {31'h0, bus.err}, 32'h0);
        check("t1_bytes", 32'(bytes_out - bytes_before), 32'd8);
        check("t1_xfers", 32'(n_xfer - xfer_before), 32'd2);
        check("t1_first_haddr", first_addr, 32'h2000_0000);
        check("t1_nonseq_latency", 32'(first_ns_cyc - start_cyc), 32'd1);

        // 2: random backpressure
        rdy_mode = 1;
        push4(8'h11, 8'h22, 8'h33, 8'h44);
        push4(8'h55, 8'h66, 8'h77, 8'h88);
        start_job(32'h2000_0000, 16'd2);
        wait_done("t2");
        check("t2_bytes", 32'(bytes_out - bytes_before), 32'd8);
        rdy_mode = 0;

        // 3: three wait states per transfer
        wait_cfg = 3;
        push4(8'h11, 8'h22, 8'h33, 8'h44);
        push4(8'h55, 8'h66, 8'h77, 8'h88);
        start_job(32'h2000_0000, 16'd2);
        wait_done("t3");
        check("t3_xfers", 32'(n_xfer - xfer_before), 32'd2);
        check("t3_bytes", 32'(bytes_out - bytes_before), 32'd8);
        wait_cfg = 0;

        // 4: error slave
        start_job(32'h4000_0000, 16'd4);
        wait_done("t4");
        check("t4_err", {31'h0, bus.err}, 32'h1);
        check("t4_bytes", 32'(bytes_out - bytes_before), 32'd0);
        check("t4_xfers", 32'(n_xfer - xfer_before), 32'd1);
        check("t4_htrans_idle", {30'h0, bus.ahbl_htrans}, 32'h0);

        // 5a: zero-length job
        start_job(32'h2000_0000, 16'd0);
        wait_done("t5a");
        check("t5a_done_latency", 32'(done_cyc - start_cyc), 32'd1);
        check("t5a_busy_cycles", 32'(busy_cnt - busy_before), 32'd0);
        check("t5a_xfers", 32'(n_xfer - xfer_before), 32'd0);

        // 5b: unaligned base is forced to a word address
        push4(8'h11, 8'h22, 8'h33, 8'h44);
        start_job(32'h2000_0003, 16'd1);
        wait_done("t5b");
        check("t5b_first_haddr", first_addr, 32'h2000_0000);
        check("t5b_err_cleared", {31'h0, bus.err}, 32'h0);

        // 6: reset while the third byte is on the stream
        push4(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        start_job(32'h3000_0000, 16'd2);
        t = 0;
        while ((bytes_out - bytes_before) < 2 && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        check("t6_reached_byte2", 32'(bytes_out - bytes_before), 32'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6_busy_after_rst", {31'h0, bus.busy}, 32'h0);
        check("t6_valid_after_rst", {31'h0, bus.out_valid}, 32'h0);
        rst = 1'b0;
        exp_q.delete();
        done_before = done_cnt;
        repeat (6) @(negedge clk);
        #2;
        check("t6_no_done", 32'(done_cnt - done_before), 32'd0);
        push4(8'h55, 8'h66, 8'h77, 8'h88);
        start_job(32'h2000_0004, 16'd1);
        wait_done("t6b");
        check("t6b_err", {31'h0, bus.err}, 32'h0);
        check("t6b_bytes", 32'(bytes_out - bytes_before), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
